// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit ALU: queues (op, a, b, acc-flag) commands in a
// small FIFO and steps each one through issue, settle, capture and result hand-off.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_acc,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  output logic [1:0] alu_ctrl,
  input  logic [3:0] alu_out,
  input  logic       alu_cout,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_cout,
  output logic [3:0] acc,
  output logic       busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full, empty, push, pop, capture;
  logic [ENT_W-1:0]   head;
  logic [3:0]         alu_in1_reg, alu_in2_reg, res_data_reg, acc_reg;
  logic [1:0]         alu_ctrl_reg;
  logic               res_cout_reg;

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign cmd_ready = !full;
  // Push depends only on !full, so a same-cycle pop never opens a slot early.
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_acc, cmd_op, cmd_a, cmd_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    res_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE:   state_next = S_CAPTURE;
      S_CAPTURE: begin
        capture    = 1'b1;
        state_next = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // acc_reg always holds the previous command's result by the time the next pop happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1_reg  <= '0;
      alu_in2_reg  <= '0;
      alu_ctrl_reg <= '0;
      res_data_reg <= '0;
      res_cout_reg <= 1'b0;
      acc_reg      <= '0;
    end else begin
      if (pop) begin
        alu_in1_reg  <= head[10] ? acc_reg : head[7:4];
        alu_in2_reg  <= head[3:0];
        alu_ctrl_reg <= head[9:8];
      end
      if (capture) begin
        res_data_reg <= alu_out;
        res_cout_reg <= alu_cout;
        acc_reg      <= alu_out;
      end
    end
  end

  assign alu_in1  = alu_in1_reg;
  assign alu_in2  = alu_in2_reg;
  assign alu_ctrl = alu_ctrl_reg;
  assign res_data = res_data_reg;
  assign res_cout = res_cout_reg;
  assign acc      = acc_reg;
  assign busy     = (state_reg != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic       cmd_acc = 1'b0;
  logic [3:0] alu_in1, alu_in2, alu_out;
  logic [1:0] alu_ctrl;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data, acc;
  logic       res_cout, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         hs_cyc[$];
  logic [3:0] model_acc = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Team ALU: AND, OR, ADD, SUB; carry on SUB is the adder carry of a + ~b + 1.
  function automatic logic [4:0] alu_f(input logic [1:0] c, input logic [3:0] x, input logic [3:0] y);
    case (c)
      2'd0:    return {1'b0, x & y};
      2'd1:    return {1'b0, x | y};
      2'd2:    return {1'b0, x} + {1'b0, y};
      default: return {1'b0, x} + {1'b0, ~y} + 5'd1;
    endcase
  endfunction

  assign {alu_cout, alu_out} = alu_f(alu_ctrl, alu_in1, alu_in2);

  alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout),
    .acc(acc), .busy(busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: compares every accepted result against the scoreboard head.
  logic       prev_hold = 1'b0;
  logic [4:0] prev_res = '0;
  always @(negedge clk) begin
    logic [4:0] e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && res_valid)
        check("res_stable", {27'd0, res_cout, res_data}, {27'd0, prev_res});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0d required=none", res_data);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e[3:0]);
          check("res_cout", res_cout, e[4]);
          check("acc_follows", acc, e[3:0]);
        end
        obs_q.push_back(res_data);
        hs_cyc.push_back(cyc);
        $display("result cyc=%0d data=%h cout=%b", cyc, res_data, res_cout);
      end
      prev_hold = res_valid && !res_ready;
      prev_res  = {res_cout, res_data};
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic f, output logic accepted);
    logic [3:0] in1;
    logic [4:0] r;
    cmd_valid = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = f;
    @(negedge clk);
    accepted = cmd_ready && !rst;
    if (accepted) begin
      in1 = f ? model_acc : a;
      r = alu_f(op, in1, b);
      model_acc = r[3:0];
      exp_q.push_back(r);
      $display("cmd cyc=%0d op=%0d a=%h b=%h acc=%b", cyc, op, a, b, f);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue_wait(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic f);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) issue(op, a, b, f, ok);
    check("issue_accepted", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_alu", {alu_in1, alu_in2, alu_ctrl}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); obs_q.delete(); hs_cyc.delete();
    model_acc = '0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   n_acc;
    logic last_ok;
    int   viol;

    // Directed ADD 5+3: operand timing and 4-cycle latency.
    do_reset();
    res_ready = 1'b1;
    issue(2'd2, 4'd5, 4'd3, 1'b0, ok);
    check("lat_accept", ok, 1);
    @(negedge clk);
    check("lat_c1_valid", res_valid, 0);
    @(negedge clk);
    check("lat_c2_in1", alu_in1, 5);
    check("lat_c2_in2", alu_in2, 3);
    check("lat_c2_ctrl", alu_ctrl, 2);
    check("lat_c2_valid", res_valid, 0);
    @(negedge clk);
    check("lat_c3_valid", res_valid, 0);
    check("lat_c3_in1", alu_in1, 5);
    @(negedge clk);
    check("lat_c4_valid", res_valid, 1);
    check("lat_c4_data", res_data, 8);
    check("lat_c4_cout", res_cout, 0);
    check("lat_c4_acc", acc, 8);
    drain();

    // Backpressure: 6 back-to-back offers with res_ready low.
    do_reset();
    res_ready = 1'b0;
    n_acc = 0;
    last_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom), ok);
      if (ok) n_acc++;
      last_ok = ok;
    end
    check("bp_accepted", n_acc, 5);
    check("bp_ready_c5", last_ok, 0);
    res_ready = 1'b1;
    drain();

    // Accumulator chain: 1, 2, 3 then 3-4 = F.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) issue_wait(2'd2, 4'($urandom), 4'd1, 1'b1);
    issue_wait(2'd3, 4'($urandom), 4'd4, 1'b1);
    drain();
    check("chain_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      check("chain_r0", obs_q[0], 1);
      check("chain_r1", obs_q[1], 2);
      check("chain_r2", obs_q[2], 3);
      check("chain_r3", obs_q[3], 15);
    end
    check("chain_acc", acc, 15);

    // Reset during CAPTURE with two commands queued.
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'b0, ok);
    @(negedge clk);
    check("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_acc = '0;
    res_ready = 1'b1;
    viol = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid) viol++;
    end
    check("mid_no_valid", viol, 0);
    check("mid_busy", busy, 0);
    check("mid_cmd_ready", cmd_ready, 1);
    check("mid_acc", acc, 0);

    // Streaming 8 commands with res_ready high: wrap-around and 4-cycle cadence.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      issue_wait(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom));
    drain();
    check("stream_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("stream_interval", hs_cyc[i] - hs_cyc[i-1], 4);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 80; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        issue(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 1'($urandom), ok);
      end
    end
    res_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
